// File: rtl/mdu_seq.sv
// Iterative unsigned MULTU/DIVU sequencer. It borrows the shared 32-bit ALU for one
// add or subtract step per cycle and holds its results in HI/LO.
`ifndef ADD_OP
`define ADD_OP 5'b00000
`endif
`ifndef SUB_OP
`define SUB_OP 5'b00001
`endif

module mdu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] opr_a_i,
  input  logic [WIDTH-1:0] opr_b_i,
  output logic [WIDTH-1:0] alu_opr_a_o,
  output logic [WIDTH-1:0] alu_opr_b_o,
  output logic [4:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_res_i,
  output logic             alu_req_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_d;
  logic             r_mode;
  logic             r_busy, r_done, r_req;

  logic             w_ov;
  logic [WIDTH-1:0] w_rs;
  logic             w_carry;
  logic             w_take;

  // Restoring-division view of the current remainder: the bit shifted out of hi
  // is kept as w_ov so that a 33-bit partial remainder still fits a 32-bit ALU.
  always_comb begin
    w_ov        = r_hi[WIDTH-1];
    w_rs        = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
    w_carry     = (alu_res_i < r_hi);
    w_take      = w_ov | (w_rs >= r_d);
    alu_opr_a_o = '0;
    alu_opr_b_o = '0;
    alu_op_o    = `ADD_OP;
    if (r_state == S_CALC) begin
      alu_opr_b_o = r_d;
      if (r_mode) begin
        alu_opr_a_o = w_rs;
        alu_op_o    = `SUB_OP;
      end else begin
        alu_opr_a_o = r_hi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_d     <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_d     <= div_i ? opr_b_i : opr_a_i;
            r_lo    <= div_i ? opr_a_i : opr_b_i;
            r_hi    <= '0;
            r_mode  <= div_i;
            r_cnt   <= '0;
            r_state <= S_CALC;
            r_busy  <= 1'b1;
            r_req   <= 1'b1;
          end
        end
        S_CALC: begin
          if (r_mode) begin
            r_hi <= w_take ? alu_res_i : w_rs;
            r_lo <= {r_lo[WIDTH-2:0], w_take};
          end else if (r_lo[0]) begin
            r_hi <= {w_carry, alu_res_i[WIDTH-1:1]};
            r_lo <= {alu_res_i[0], r_lo[WIDTH-1:1]};
          end else begin
            r_hi <= {1'b0, r_hi[WIDTH-1:1]};
            r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_req_o = r_req;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign hi_o      = r_hi;
  assign lo_o      = r_lo;

endmodule
